// File: rtl/write_module.sv
// write_module: vector/scalar store stage, the write-back counterpart of the sequential
// read stage. A start pulse accepted in IDLE snapshots an I-item vector (or one scalar)
// and a base address. The stage then issues one memory write per clock to consecutive,
// wrapping addresses, and ends with a one-cycle finished pulse.
//
// Ports:
//   clk            system clock, all state on posedge
//   rst            asynchronous reset, active-high
//   start          one-cycle request, honoured only in IDLE
//   op_type        1 = vector store (I items), 0 = scalar store (1 item)
//   base_address   first memory address of the store
//   vector_data    packed [I-1:0][L-1:0] items; item 0 written first
//   scalar_data    value stored when op_type = 0
//   write_enable   memory write strobe
//   write_address  memory address for the current write
//   write_data     memory data for the current write
//   busy           high from the cycle after start is accepted until finished is high
//   finished       one-cycle pulse after the last write
//
// Every output is a register fed from the FSM state, so the visible write stream lags
// the FSM by one clock: with start sampled at edge 0, writes appear in cycles 1..N and
// finished in cycle N+1.
module write_module #(
  parameter int unsigned I = 20,  // items per vector; must satisfy I <= 2**A
  parameter int unsigned L = 32,  // item width
  parameter int unsigned A = 6    // address width
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op_type,
  input  logic [A-1:0]        base_address,
  input  logic [I-1:0][L-1:0] vector_data,
  input  logic [L-1:0]        scalar_data,
  output logic                write_enable,
  output logic [A-1:0]        write_address,
  output logic [L-1:0]        write_data,
  output logic                busy,
  output logic                finished
);

  localparam int unsigned     IdxW    = (I > 1) ? $clog2(I) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(I - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 op_q, op_d;
  logic [A-1:0]         base_q, base_d;
  logic [I-1:0][L-1:0]  buf_q, buf_d;

  logic                 write_enable_d;
  logic [A-1:0]         write_address_d;
  logic [L-1:0]         write_data_d;
  logic                 busy_d;
  logic                 finished_d;

  logic                 last_item;

  // A scalar store always ends after slot 0.
  assign last_item = op_q ? (idx_q == LastIdx) : 1'b1;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    base_d  = base_q;
    buf_d   = buf_q;

    case (state_q)
      StIdle: begin
        // finished is still high during the first IDLE cycle; a start seen then belongs
        // to the store that just ended and is dropped.
        if (start && !finished) begin
          op_d   = op_type;
          base_d = base_address;
          idx_d  = '0;
          if (op_type) begin
            buf_d = vector_data;
          end else begin
            buf_d    = '0;
            buf_d[0] = scalar_data;
          end
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (last_item) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered outputs decoded from the current state
  always_comb begin
    write_enable_d  = 1'b0;
    write_address_d = '0;
    write_data_d    = '0;
    busy_d          = 1'b0;
    finished_d      = 1'b0;

    case (state_q)
      StWrite: begin
        write_enable_d  = 1'b1;
        // A-bit sum: wraps modulo 2**A
        write_address_d = base_q + A'(idx_q);
        write_data_d    = buf_q[idx_q];
        busy_d          = 1'b1;
      end
      StDone: begin
        busy_d     = 1'b1;
        finished_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      op_q          <= 1'b0;
      base_q        <= '0;
      buf_q         <= '0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      busy          <= 1'b0;
      finished      <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      op_q          <= op_d;
      base_q        <= base_d;
      buf_q         <= buf_d;
      write_enable  <= write_enable_d;
      write_address <= write_address_d;
      write_data    <= write_data_d;
      busy          <= busy_d;
      finished      <= finished_d;
    end
  end

endmodule

// File: tb/tb_write_module.sv
// Directed testbench for write_module. Cycle n means the interval just after clock
// edge n, where edge 0 is the edge that samples start. Outputs are sampled 1 ns after
// each posedge; inputs are driven at the same point, well away from the next edge.
module tb_write_module;

  localparam int unsigned I = 20;
  localparam int unsigned L = 32;
  localparam int unsigned A = 6;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                op_type = 1'b0;
  logic [A-1:0]        base_address = '0;
  logic [I-1:0][L-1:0] vector_data = '0;
  logic [L-1:0]        scalar_data = '0;
  logic                write_enable;
  logic [A-1:0]        write_address;
  logic [L-1:0]        write_data;
  logic                busy;
  logic                finished;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  write_module #(
    .I(I),
    .L(L),
    .A(A)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op_type      (op_type),
    .base_address (base_address),
    .vector_data  (vector_data),
    .scalar_data  (scalar_data),
    .write_enable (write_enable),
    .write_address(write_address),
    .write_data   (write_data),
    .busy         (busy),
    .finished     (finished)
  );

  // Reset: outputs clear while held, clear immediately on a mid-store assert, and stay
  // quiet afterwards while start is low.
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({write_enable, write_address, write_data, busy, finished} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: we=%0b addr=%0d data=%h busy=%0b fin=%0b, want all 0",
               write_enable, write_address, write_data, busy, finished);
    end
    #2 rst = 1'b0;
    // Start a store so the asynchronous assert below has something to clear.
    for (int k = 0; k < I; k++) vector_data[k] = 32'h700 + k;
    base_address = 6'd3;
    op_type = 1'b1;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if ({write_enable, write_address, write_data, busy, finished} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: we=%0b addr=%0d data=%h busy=%0b fin=%0b, want all 0",
               write_enable, write_address, write_data, busy, finished);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if ({write_enable, finished} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: we=%0b fin=%0b, want 0 0",
                 n, write_enable, finished);
      end
    end
  endtask

  // Full vector store from base with items data_base+k; checks cycles 1..I+2.
  task automatic test_vector_store(input logic [A-1:0] base, input logic [L-1:0] data_base,
                                   input string name);
    logic         exp_we, exp_busy, exp_fin;
    logic [A-1:0] exp_addr;
    logic [L-1:0] exp_data;
    for (int k = 0; k < I; k++) vector_data[k] = data_base + k;
    base_address = base;
    op_type = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    // Scramble inputs; the snapshot must be unaffected.
    vector_data  = '1;
    base_address = ~base;
    op_type      = 1'b0;
    for (int n = 1; n <= I + 2; n++) begin
      @(posedge clk);
      #1;
      exp_we   = (n <= I);
      exp_busy = (n <= I + 1);
      exp_fin  = (n == I + 1);
      exp_addr = base + (n - 1);
      exp_data = data_base + (n - 1);
      n_tests++;
      if ({write_enable, busy, finished} !== {exp_we, exp_busy, exp_fin} ||
          (exp_we && {write_address, write_data} !== {exp_addr, exp_data})) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got we=%0b addr=%0d data=%h busy=%0b fin=%0b, want we=%0b addr=%0d data=%h busy=%0b fin=%0b",
                 name, n, write_enable, write_address, write_data, busy, finished,
                 exp_we, exp_addr, exp_data, exp_busy, exp_fin);
      end
    end
  endtask

  // Scalar store: one write in cycle 1, finished in cycle 2, idle in cycle 3.
  task automatic test_scalar_store();
    logic [2:0] exp_ctl [1:3];
    exp_ctl[1] = 3'b110;  // {we, busy, fin}
    exp_ctl[2] = 3'b011;
    exp_ctl[3] = 3'b000;
    for (int k = 0; k < I; k++) vector_data[k] = 32'h5555_0000 + k;
    scalar_data  = 32'hDEADBEEF;
    base_address = 6'd5;
    op_type      = 1'b0;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    scalar_data = 32'h0;
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if ({write_enable, busy, finished} !== exp_ctl[n] ||
          (n == 1 && {write_address, write_data} !== {6'd5, 32'hDEADBEEF})) begin
        n_fail++;
        $display("FAIL scalar cycle %0d: got we=%0b addr=%0d data=%h busy=%0b fin=%0b, want ctl=%b addr=5 data=deadbeef",
                 n, write_enable, write_address, write_data, busy, finished, exp_ctl[n]);
      end
    end
  endtask

  // New data and a start during cycle 5 change nothing; a start during the finished
  // cycle is also dropped, so nothing follows the store.
  task automatic test_snapshot();
    logic exp_we, exp_busy, exp_fin;
    for (int k = 0; k < I; k++) vector_data[k] = 32'h200 + k;
    base_address = 6'd0;
    op_type = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= I + 10; n++) begin
      @(posedge clk);
      #1;
      exp_we   = (n <= I);
      exp_busy = (n <= I + 1);
      exp_fin  = (n == I + 1);
      n_tests++;
      if ({write_enable, busy, finished} !== {exp_we, exp_busy, exp_fin} ||
          (exp_we && {write_address, write_data} !== {6'(n - 1), 32'h200 + 32'(n - 1)})) begin
        n_fail++;
        $display("FAIL snapshot cycle %0d: got we=%0b addr=%0d data=%h busy=%0b fin=%0b, want we=%0b addr=%0d data=%h busy=%0b fin=%0b",
                 n, write_enable, write_address, write_data, busy, finished,
                 exp_we, n - 1, 32'h200 + n - 1, exp_busy, exp_fin);
      end
      if (n == 5) begin
        for (int k = 0; k < I; k++) vector_data[k] = 32'hBAD0_0000 + k;
        base_address = 6'd33;
        start = 1'b1;
      end else if (n == I + 1) begin
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  // Reset during the 8th write aborts with no finished pulse; a later store is complete.
  task automatic test_abort();
    for (int k = 0; k < I; k++) vector_data[k] = 32'h300 + k;
    base_address = 6'd20;
    op_type = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if ({write_enable, busy, finished, write_address, write_data} !==
          {3'b110, 6'(20 + n - 1), 32'h300 + 32'(n - 1)}) begin
        n_fail++;
        $display("FAIL abort_pre cycle %0d: got we=%0b addr=%0d data=%h busy=%0b fin=%0b, want we=1 addr=%0d data=%h busy=1 fin=0",
                 n, write_enable, write_address, write_data, busy, finished,
                 20 + n - 1, 32'h300 + n - 1);
      end
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({write_enable, busy, finished} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_drop: we=%0b busy=%0b fin=%0b, want 0 0 0",
               write_enable, busy, finished);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if ({write_enable, busy, finished} !== 3'b000) begin
        n_fail++;
        $display("FAIL abort_after cycle %0d: we=%0b busy=%0b fin=%0b, want 0 0 0",
                 n, write_enable, busy, finished);
      end
    end
    test_vector_store(6'd20, 32'h400, "post_abort");
  endtask

  initial begin
    test_reset();
    test_vector_store(6'd10, 32'h100, "vector");
    test_scalar_store();
    test_vector_store(6'd60, 32'h500, "wrap");
    test_snapshot();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
